// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment display path: digit count,
// overflow glyph, converter FSM encoding and segment codes used by the driver.
package sseg_pkg;

  // Default number of displayed BCD digits
  localparam int DIGITS_DEF = 8;

  // Digit value shown in every position when the count does not fit
  localparam logic [3:0] BCD_OVF_DIGIT = 4'hE;

  // Binary-to-BCD converter states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  // Segment codes, bit order {g,f,e,d,c,b,a}, active high
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Segment pattern for one BCD digit; anything outside 0-9 and E is blanked
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hE:    seg = SEG_E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sseg_bin2bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the
// shift so that doubling carries correctly into the next digit.
module bcd_add3
  import sseg_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Pure 4-bit correction; no carry leaves the digit
  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/sseg_bin2bcd.sv
// Sequential binary-to-BCD converter, one input bit per clock, feeding the
// 8-digit seven-segment driver. Outputs only change on the completion edge so
// the display never shows a partially converted value.
module sseg_bin2bcd
  import sseg_pkg::*;
#(
  parameter int IN_W   = 27,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     nz,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

  // Largest displayable value, clipped to 2^IN_W when the input can never
  // reach 10^DIGITS. Worked out with spare bits so nothing truncates.
  function automatic logic [IN_W:0] calc_limit();
    logic [IN_W+4:0] p;
    logic [IN_W+4:0] top;
    top = (IN_W+5)'(1) << IN_W;
    p   = (IN_W+5)'(1);
    for (int d = 0; d < DIGITS; d++) begin
      if (p <= top) p = p * (IN_W+5)'(10);
    end
    p = p - (IN_W+5)'(1);
    if (p > top) p = top;
    return p[IN_W:0];
  endfunction

  localparam logic [IN_W:0] BCD_MAX = calc_limit();

  conv_state_t        state_reg, state_next;
  logic [IN_W-1:0]    sh_reg, sh_next;
  logic [BCD_W-1:0]   acc_reg, acc_next;
  logic [BCD_W-1:0]   acc_adj;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               pend_ovf_reg, pend_ovf_next;
  logic               out_load;

  logic [BCD_W-1:0]   bcd_reg;
  logic [DIGITS-1:0]  nz_reg;
  logic               ovf_reg;
  logic               done_reg;
  logic [BCD_W-1:0]   bcd_next;
  logic [DIGITS-1:0]  nz_next;

  // Per-digit +3 correction on the pre-shift accumulator, all digits in parallel
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .din  (acc_reg[4*gi +: 4]),
        .dout (acc_adj[4*gi +: 4])
      );
    end
  endgenerate

  // Value presented at completion: overflow glyph or the converted digits
  assign bcd_next = pend_ovf_reg ? {DIGITS{BCD_OVF_DIGIT}} : acc_reg;

  // Significant-digit mask: a digit is lit if it or any higher digit is nonzero
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nz
      if (gi == 0) begin : g_lsd
        assign nz_next[gi] = 1'b1;
      end else begin : g_hi
        assign nz_next[gi] = |bcd_next[BCD_W-1:4*gi];
      end
    end
  endgenerate

  // Next-state, datapath and output-load decode
  always_comb begin
    state_next    = state_reg;
    sh_next       = sh_reg;
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    pend_ovf_next = pend_ovf_reg;
    out_load      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          sh_next       = bin;
          acc_next      = '0;
          cnt_next      = CNT_W'(IN_W - 1);
          pend_ovf_next = ({1'b0, bin} > BCD_MAX);
          state_next    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {acc_next, sh_next} = {acc_adj, sh_reg} << 1;
        if (cnt_reg == '0) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_DONE: begin
        out_load   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, datapath and held output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      sh_reg       <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      pend_ovf_reg <= 1'b0;
      bcd_reg      <= '0;
      nz_reg       <= {{(DIGITS-1){1'b0}}, 1'b1};
      ovf_reg      <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sh_reg       <= sh_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      pend_ovf_reg <= pend_ovf_next;
      done_reg     <= out_load;
      if (out_load) begin
        bcd_reg <= bcd_next;
        nz_reg  <= nz_next;
        ovf_reg <= pend_ovf_reg;
      end
    end
  end

  assign busy = (state_reg != ST_IDLE);
  assign done = done_reg;
  assign bcd  = bcd_reg;
  assign nz   = nz_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_sseg_bin2bcd.sv
// Directed and random checks for the sequential binary-to-BCD converter.
module tb_sseg_bin2bcd;

  localparam int IN_W   = 27;
  localparam int DIGITS = 8;
  localparam int LAT    = IN_W + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [IN_W-1:0]   bin = '0;
  logic              busy;
  logic              done;
  logic [31:0]       bcd;
  logic [7:0]        nz;
  logic              ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // results of the most recent do_convert
  logic [31:0] r_bcd;
  logic [7:0]  r_nz;
  logic        r_ovf;
  int          r_cyc;
  int          r_busy_cnt;
  logic        r_busy_at_done;
  int          r_unstable;

  sseg_bin2bcd #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .nz    (nz),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_bcd(input logic [IN_W-1:0] v);
    int unsigned x;
    logic [31:0] r;
    r = '0;
    if (v > 27'd99_999_999) return 32'hEEEE_EEEE;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] model_nz(input logic [31:0] b);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = ((b >> (4*i)) != 32'd0);
    m[0] = 1'b1;
    return m;
  endfunction

  // Drives one start pulse and waits for done; records what happened
  task automatic do_convert(input logic [IN_W-1:0] v);
    logic [31:0] s_bcd;
    logic [7:0]  s_nz;
    logic        s_ovf;
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    s_bcd = bcd; s_nz = nz; s_ovf = ovf;
    @(negedge clk);
    start = 1'b0;
    r_cyc = 1;
    r_busy_cnt = 0;
    r_unstable = 0;
    while (!done && r_cyc < 100) begin
      if (busy) r_busy_cnt++;
      if (bcd !== s_bcd || nz !== s_nz || ovf !== s_ovf) r_unstable++;
      @(negedge clk);
      r_cyc++;
    end
    r_bcd = bcd; r_nz = nz; r_ovf = ovf;
    r_busy_at_done = busy;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 32'h0 || nz !== 8'h01 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b bcd=%h nz=%h ovf=%b, required 0 0 00000000 01 0",
               busy, done, bcd, nz, ovf);
    end
    rst_n = 1'b1;
    $display("[TB] reset checked");
  endtask

  task automatic test_latency;
    do_convert('0);
    n_tests++;
    if (r_cyc !== LAT) begin
      n_fail++;
      $display("FAIL latency: done at cycle %0d, required %0d", r_cyc, LAT);
    end
    n_tests++;
    if (r_bcd !== 32'h0 || r_nz !== 8'h01 || r_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_value: bcd=%h nz=%h ovf=%b, required 00000000 01 0", r_bcd, r_nz, r_ovf);
    end
    n_tests++;
    if (r_busy_cnt !== LAT - 1 || r_busy_at_done !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_window: busy cycles=%0d busy_at_done=%b, required %0d 0",
               r_busy_cnt, r_busy_at_done, LAT - 1);
    end
    $display("[TB] bin=0 done_cycle=%0d bcd=%h nz=%h ovf=%b", r_cyc, r_bcd, r_nz, r_ovf);
  endtask

  task automatic test_values;
    logic [IN_W-1:0] vin  [6] = '{27'd12_345_678, 27'd905, 27'd99_999_999,
                                  27'd100_000_000, 27'd7, 27'd1_000};
    logic [31:0]     ebcd [6] = '{32'h1234_5678, 32'h0000_0905, 32'h9999_9999,
                                  32'hEEEE_EEEE, 32'h0000_0007, 32'h0000_1000};
    logic [7:0]      enz  [6] = '{8'hFF, 8'h07, 8'hFF, 8'hFF, 8'h01, 8'h0F};
    logic            eovf [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      do_convert(vin[i]);
      n_tests++;
      if (r_bcd !== ebcd[i] || r_nz !== enz[i] || r_ovf !== eovf[i] || r_cyc !== LAT) begin
        n_fail++;
        $display("FAIL value_%0d: bin=%0d bcd=%h nz=%h ovf=%b cyc=%0d, required %h %h %b %0d",
                 i, vin[i], r_bcd, r_nz, r_ovf, r_cyc, ebcd[i], enz[i], eovf[i], LAT);
      end
      n_tests++;
      if (r_unstable !== 0) begin
        n_fail++;
        $display("FAIL stable_%0d: outputs changed on %0d non-done cycles, required 0", i, r_unstable);
      end
      $display("[TB] bin=%0d bcd=%h nz=%h ovf=%b", vin[i], r_bcd, r_nz, r_ovf);
    end
  endtask

  task automatic test_ignore_start;
    int          n_done;
    logic [31:0] got;
    n_done = 0;
    got = '0;
    @(negedge clk);
    start = 1'b1;
    bin   = 27'd42;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 70; c++) begin
      if (c == 10) begin start = 1'b1; bin = 27'd99; end
      if (c == 11) start = 1'b0;
      if (done) begin n_done++; got = bcd; end
      @(negedge clk);
    end
    n_tests++;
    if (n_done !== 1 || got !== 32'h42) begin
      n_fail++;
      $display("FAIL ignore_start: done pulses=%0d bcd=%h, required 1 00000042", n_done, got);
    end
    $display("[TB] start mid-shift ignored: pulses=%0d bcd=%h", n_done, got);
  endtask

  task automatic test_back_to_back;
    int n_done;
    int last;
    int c;
    n_done = 0;
    last = 0;
    c = 0;
    @(negedge clk);
    start = 1'b1;
    bin   = 27'd1;
    while (n_done < 5 && c < 6 * LAT) begin
      @(negedge clk);
      c++;
      if (done) begin
        n_done++;
        n_tests++;
        if (bcd !== 32'(n_done) || c - last !== LAT) begin
          n_fail++;
          $display("FAIL back_to_back_%0d: bcd=%h interval=%0d, required %h %0d",
                   n_done, bcd, c - last, 32'(n_done), LAT);
        end
        $display("[TB] held start result %0d: bcd=%h interval=%0d", n_done, bcd, c - last);
        last = c;
        if (n_done < 5) bin = IN_W'(n_done + 1);
        else start = 1'b0;
      end
    end
    start = 1'b0;
    n_tests++;
    if (n_done !== 5) begin
      n_fail++;
      $display("FAIL back_to_back_count: %0d results, required 5", n_done);
    end
  endtask

  task automatic test_reset_mid;
    int n_done;
    do_convert(27'd1234);
    n_tests++;
    if (r_bcd !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL pre_reset: bcd=%h, required 00001234", r_bcd);
    end
    @(negedge clk);
    start = 1'b1;
    bin   = 27'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_tests++;
    if (bcd !== 32'h0 || nz !== 8'h01 || busy !== 1'b0 || ovf !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: bcd=%h nz=%h busy=%b ovf=%b done=%b, required 00000000 01 0 0 0",
               bcd, nz, busy, ovf, done);
    end
    n_done = 0;
    repeat (40) begin
      if (done) n_done++;
      @(negedge clk);
    end
    n_tests++;
    if (n_done !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: %0d done pulses after reset, required 0", n_done);
    end
    do_convert(27'd321);
    n_tests++;
    if (r_bcd !== 32'h0000_0321 || r_nz !== 8'h07 || r_cyc !== LAT) begin
      n_fail++;
      $display("FAIL post_reset: bcd=%h nz=%h cyc=%0d, required 00000321 07 %0d", r_bcd, r_nz, r_cyc, LAT);
    end
    $display("[TB] reset mid-shift: post-reset bcd=%h", r_bcd);
  endtask

  task automatic test_random;
    logic [IN_W-1:0] v;
    logic [31:0]     eb;
    int              bad;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      if (i % 16 == 0) v = IN_W'($urandom_range(99_999_990, 100_000_010));
      else             v = IN_W'($urandom_range(0, (1 << IN_W) - 1));
      do_convert(v);
      eb = model_bcd(v);
      n_tests++;
      if (r_bcd !== eb || r_nz !== model_nz(eb) || r_ovf !== (v > 27'd99_999_999) ||
          r_unstable !== 0 || r_cyc !== LAT) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random: bin=%0d bcd=%h nz=%h ovf=%b unstable=%0d cyc=%0d, required %h %h %b 0 %0d",
                   v, r_bcd, r_nz, r_ovf, r_unstable, r_cyc, eb, model_nz(eb),
                   (v > 27'd99_999_999), LAT);
      end
    end
    $display("[TB] random sweep of 2000 values: %0d bad", bad);
  endtask

  initial begin
    test_reset;
    test_latency;
    test_values;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
